// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared types and constants for match scoring
package pong_pkg;

  typedef enum logic [1:0] {
    PLAY      = 2'd0,
    HOLDOFF   = 2'd1,
    GAME_OVER = 2'd2
  } score_state_t;

  typedef logic [3:0] bcd_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  // Two-digit BCD image of a binary value, used for elaboration-time constants.
  function automatic logic [7:0] to_bcd2(input int unsigned value);
    logic [7:0] r_bcd;
    r_bcd[7:4] = 4'((value / 10) % 10);
    r_bcd[3:0] = 4'(value % 10);
    return r_bcd;
  endfunction

endpackage

// File: rtl/bcd_counter2.sv
// rtl/bcd_counter2.sv - saturating two-digit BCD counter with synchronous clear
module bcd_counter2
  import pong_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output bcd_t o_bcd0,
  output bcd_t o_bcd1
);

  bcd_t r_bcd0;
  bcd_t r_bcd1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bcd0 <= 4'd0;
      r_bcd1 <= 4'd0;
    end else if (i_clr) begin
      r_bcd0 <= 4'd0;
      r_bcd1 <= 4'd0;
    end else if (i_inc) begin
      // 99 holds rather than wrapping to 00
      if (r_bcd1 == 4'd9 && r_bcd0 == 4'd9) begin
        r_bcd0 <= r_bcd0;
        r_bcd1 <= r_bcd1;
      end else if (r_bcd0 == 4'd9) begin
        r_bcd0 <= 4'd0;
        r_bcd1 <= r_bcd1 + 4'd1;
      end else begin
        r_bcd0 <= r_bcd0 + 4'd1;
      end
    end
  end

  assign o_bcd0 = r_bcd0;
  assign o_bcd1 = r_bcd1;

endmodule

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - goal edge detect, BCD scores, hold-off and game-over control
module score_keeper
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE      = 11,
  parameter int unsigned HOLDOFF_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       score_p1,
  input  logic       score_p2,
  input  logic       new_game,
  output bcd_t       p1_bcd0,
  output bcd_t       p1_bcd1,
  output bcd_t       p2_bcd0,
  output bcd_t       p2_bcd1,
  output logic       point_pulse,
  output logic       game_over,
  output logic [1:0] winner,
  output logic       ball_freeze
);

  // A goal wins when the score before it equals WIN_SCORE-1, so winner and
  // final digits land on the same edge.
  localparam logic [7:0]    WIN_M1_BCD = to_bcd2(WIN_SCORE - 1);
  localparam int            CW         = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLDOFF_CYCLES - 1);

  score_state_t  r_state;
  score_state_t  w_next_state;
  logic          r_p1_q;
  logic          r_p2_q;
  logic          r_ng_q;
  logic          r_rise_p1;
  logic          r_rise_p2;
  logic [CW-1:0] r_hold_cnt;
  logic          r_point_pulse;
  logic          r_game_over;
  logic          r_ball_freeze;
  logic [1:0]    r_winner;
  logic [1:0]    w_next_winner;
  logic          w_inc_p1;
  logic          w_inc_p2;
  logic          w_clr;
  logic          w_ng_rise;
  bcd_t          w_p1_bcd0;
  bcd_t          w_p1_bcd1;
  bcd_t          w_p2_bcd0;
  bcd_t          w_p2_bcd1;

  assign w_ng_rise = new_game & ~r_ng_q;

  bcd_counter2 u_p1_cnt (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_inc   (w_inc_p1),
    .i_clr   (w_clr),
    .o_bcd0  (w_p1_bcd0),
    .o_bcd1  (w_p1_bcd1)
  );

  bcd_counter2 u_p2_cnt (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_inc   (w_inc_p2),
    .i_clr   (w_clr),
    .o_bcd0  (w_p2_bcd0),
    .o_bcd1  (w_p2_bcd1)
  );

  always_comb begin
    w_next_state  = r_state;
    w_next_winner = r_winner;
    w_inc_p1      = 1'b0;
    w_inc_p2      = 1'b0;
    w_clr         = 1'b0;
    case (r_state)
      PLAY: begin
        if (r_rise_p1 && r_rise_p2) begin
          w_next_state = HOLDOFF;
        end else if (r_rise_p1) begin
          w_inc_p1 = 1'b1;
          if ({w_p1_bcd1, w_p1_bcd0} == WIN_M1_BCD) begin
            w_next_state  = GAME_OVER;
            w_next_winner = WIN_P1;
          end else begin
            w_next_state = HOLDOFF;
          end
        end else if (r_rise_p2) begin
          w_inc_p2 = 1'b1;
          if ({w_p2_bcd1, w_p2_bcd0} == WIN_M1_BCD) begin
            w_next_state  = GAME_OVER;
            w_next_winner = WIN_P2;
          end else begin
            w_next_state = HOLDOFF;
          end
        end
      end
      HOLDOFF: begin
        if (r_hold_cnt == HOLD_LAST) w_next_state = PLAY;
      end
      GAME_OVER: begin
        if (w_ng_rise) begin
          w_clr         = 1'b1;
          w_next_winner = WIN_NONE;
          w_next_state  = PLAY;
        end
      end
      default: w_next_state = PLAY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= PLAY;
      r_p1_q        <= 1'b0;
      r_p2_q        <= 1'b0;
      r_ng_q        <= 1'b0;
      r_rise_p1     <= 1'b0;
      r_rise_p2     <= 1'b0;
      r_hold_cnt    <= '0;
      r_point_pulse <= 1'b0;
      r_game_over   <= 1'b0;
      r_ball_freeze <= 1'b0;
      r_winner      <= WIN_NONE;
    end else begin
      r_p1_q        <= score_p1;
      r_p2_q        <= score_p2;
      r_ng_q        <= new_game;
      // Rises seen outside PLAY are dropped so none leaks past hold-off or game over
      r_rise_p1     <= score_p1 & ~r_p1_q & (r_state == PLAY);
      r_rise_p2     <= score_p2 & ~r_p2_q & (r_state == PLAY);
      r_hold_cnt    <= (r_state == HOLDOFF && r_hold_cnt != HOLD_LAST) ? r_hold_cnt + 1'b1 : '0;
      r_point_pulse <= w_inc_p1 | w_inc_p2;
      r_game_over   <= (w_next_state == GAME_OVER);
      r_ball_freeze <= (w_next_state != PLAY);
      r_winner      <= w_next_winner;
      r_state       <= w_next_state;
    end
  end

  assign p1_bcd0     = w_p1_bcd0;
  assign p1_bcd1     = w_p1_bcd1;
  assign p2_bcd0     = w_p2_bcd0;
  assign p2_bcd1     = w_p2_bcd1;
  assign point_pulse = r_point_pulse;
  assign game_over   = r_game_over;
  assign winner      = r_winner;
  assign ball_freeze = r_ball_freeze;

endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - scoreboard bench for score_keeper
module tb_score_keeper;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       score_p1 = 1'b0, score_p2 = 1'b0, new_game = 1'b0;
  logic [3:0] p1_bcd0, p1_bcd1, p2_bcd0, p2_bcd1;
  logic       point_pulse, game_over, ball_freeze;
  logic [1:0] winner;

  logic       s99_p1 = 1'b0, s99_p2 = 1'b0, ng99 = 1'b0;
  logic [3:0] q1_bcd0, q1_bcd1, q2_bcd0, q2_bcd1;
  logic       q_pulse, q_over, q_freeze;
  logic [1:0] q_winner;

  always #5 clk = ~clk;

  score_keeper #(.WIN_SCORE(11), .HOLDOFF_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .score_p1(score_p1), .score_p2(score_p2), .new_game(new_game),
    .p1_bcd0(p1_bcd0), .p1_bcd1(p1_bcd1), .p2_bcd0(p2_bcd0), .p2_bcd1(p2_bcd1),
    .point_pulse(point_pulse), .game_over(game_over), .winner(winner), .ball_freeze(ball_freeze)
  );

  score_keeper #(.WIN_SCORE(99), .HOLDOFF_CYCLES(2)) dut99 (
    .clk(clk), .reset(reset), .score_p1(s99_p1), .score_p2(s99_p2), .new_game(ng99),
    .p1_bcd0(q1_bcd0), .p1_bcd1(q1_bcd1), .p2_bcd0(q2_bcd0), .p2_bcd1(q2_bcd1),
    .point_pulse(q_pulse), .game_over(q_over), .winner(q_winner), .ball_freeze(q_freeze)
  );

  typedef struct {
    logic [7:0] p1;
    logic [7:0] p2;
    logic [1:0] win;
    logic       go;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   pulse_cnt = 0;
  int   freeze_cnt = 0;
  int   m_p1 = 0;
  int   m_p2 = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      if (ball_freeze) freeze_cnt++;
      if (point_pulse) begin
        pulse_cnt++;
        if (sb.size() == 0) begin
          check("sb_unexpected_pulse", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_p1", {24'd0, p1_bcd1, p1_bcd0}, {24'd0, e.p1});
          check("sb_p2", {24'd0, p2_bcd1, p2_bcd0}, {24'd0, e.p2});
          check("sb_winner", {30'd0, winner}, {30'd0, e.win});
          check("sb_game_over", {31'd0, game_over}, {31'd0, e.go});
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_clear();
    int n = 0;
    while (ball_freeze && n < 200) begin
      tick();
      n++;
    end
    check("freeze_release", {31'd0, ball_freeze}, 32'd0);
  endtask

  // Drives one accepted goal and records the expected post-goal state.
  task automatic goal(input int who, input int hold);
    exp_t e;
    if (who == 1) m_p1++; else m_p2++;
    e.p1  = bcd(m_p1);
    e.p2  = bcd(m_p2);
    e.win = (m_p1 == 11) ? 2'b01 : (m_p2 == 11) ? 2'b10 : 2'b00;
    e.go  = (m_p1 == 11 || m_p2 == 11);
    sb.push_back(e);
    if (who == 1) score_p1 = 1'b1; else score_p2 = 1'b1;
    tick(hold);
    score_p1 = 1'b0;
    score_p2 = 1'b0;
    if (!e.go) begin
      wait_clear();
      tick(2);
    end else begin
      tick(3);
    end
  endtask

  task automatic goal99();
    s99_p1 = 1'b1;
    tick();
    s99_p1 = 1'b0;
    tick(6);
  endtask

  int snap_p, snap_f;

  initial begin
    tick(2);
    check("rst_digits", {16'd0, p1_bcd1, p1_bcd0, p2_bcd1, p2_bcd0}, 32'd0);
    check("rst_flags", {28'd0, point_pulse, game_over, ball_freeze, 1'b0}, 32'd0);
    check("rst_winner", {30'd0, winner}, 32'd0);
    reset = 1'b1;
    tick();

    // long strobe counts once; freeze lasts HOLDOFF_CYCLES
    snap_p = pulse_cnt;
    snap_f = freeze_cnt;
    goal(1, 50);
    check("long_p1", {24'd0, p1_bcd1, p1_bcd0}, 32'h01);
    check("long_pulses", pulse_cnt - snap_p, 32'd1);
    check("long_freeze", freeze_cnt - snap_f, 32'd16);

    // ten p2 goals, units wrap 9 -> 10
    for (int i = 0; i < 10; i++) begin
      goal(2, 3);
      if (i == 8) check("p2_nine", {24'd0, p2_bcd1, p2_bcd0}, 32'h09);
    end
    check("p2_ten", {24'd0, p2_bcd1, p2_bcd0}, 32'h10);

    // simultaneous goals: no point, hold-off entered
    snap_p = pulse_cnt;
    score_p1 = 1'b1;
    score_p2 = 1'b1;
    tick(3);
    check("both_freeze", {31'd0, ball_freeze}, 32'd1);
    score_p1 = 1'b0;
    score_p2 = 1'b0;
    wait_clear();
    check("both_digits", {16'd0, p1_bcd1, p1_bcd0, p2_bcd1, p2_bcd0}, 32'h0110);
    check("both_pulses", pulse_cnt - snap_p, 32'd0);

    // strobe during hold-off ignored
    snap_p = pulse_cnt;
    m_p1++;
    sb.push_back('{p1: bcd(m_p1), p2: bcd(m_p2), win: 2'b00, go: 1'b0});
    score_p1 = 1'b1;
    tick(3);
    score_p1 = 1'b0;
    tick(2);
    score_p2 = 1'b1;
    tick(3);
    score_p2 = 1'b0;
    wait_clear();
    tick(2);
    check("holdoff_digits", {16'd0, p1_bcd1, p1_bcd0, p2_bcd1, p2_bcd0}, 32'h0210);
    check("holdoff_pulses", pulse_cnt - snap_p, 32'd1);

    // asynchronous reset mid hold-off
    m_p1++;
    sb.push_back('{p1: bcd(m_p1), p2: bcd(m_p2), win: 2'b00, go: 1'b0});
    score_p1 = 1'b1;
    tick(3);
    score_p1 = 1'b0;
    tick(4);
    check("pre_reset_freeze", {31'd0, ball_freeze}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("arst_digits", {16'd0, p1_bcd1, p1_bcd0, p2_bcd1, p2_bcd0}, 32'd0);
    check("arst_flags", {27'd0, point_pulse, game_over, ball_freeze, winner}, 32'd0);
    tick();
    reset = 1'b1;
    m_p1 = 0;
    m_p2 = 0;
    sb.delete();
    snap_p = pulse_cnt;
    tick(3);
    check("post_reset_pulses", pulse_cnt - snap_p, 32'd0);

    // p1 reaches WIN_SCORE
    for (int i = 0; i < 11; i++) goal(1, 3);
    check("win_over", {31'd0, game_over}, 32'd1);
    check("win_winner", {30'd0, winner}, 32'd1);
    check("win_freeze", {31'd0, ball_freeze}, 32'd1);
    snap_p = pulse_cnt;
    score_p2 = 1'b1;
    tick(3);
    score_p2 = 1'b0;
    score_p1 = 1'b1;
    tick(3);
    score_p1 = 1'b0;
    tick(30);
    check("over_frozen", {16'd0, p1_bcd1, p1_bcd0, p2_bcd1, p2_bcd0}, 32'h1100);
    check("over_pulses", pulse_cnt - snap_p, 32'd0);
    new_game = 1'b1;
    tick(2);
    new_game = 1'b0;
    check("ng_digits", {16'd0, p1_bcd1, p1_bcd0, p2_bcd1, p2_bcd0}, 32'd0);
    check("ng_flags", {28'd0, game_over, ball_freeze, winner}, 32'd0);
    m_p1 = 0;
    m_p2 = 0;

    // new_game in PLAY has no effect
    goal(2, 3);
    new_game = 1'b1;
    tick(2);
    new_game = 1'b0;
    tick(2);
    check("ng_in_play", {16'd0, p1_bcd1, p1_bcd0, p2_bcd1, p2_bcd0}, 32'h0001);

    // WIN_SCORE=99 instance: 98 then final goal, no wrap
    for (int i = 0; i < 98; i++) goal99();
    check("w99_98", {24'd0, q1_bcd1, q1_bcd0}, 32'h98);
    check("w99_98_over", {31'd0, q_over}, 32'd0);
    goal99();
    check("w99_99", {24'd0, q1_bcd1, q1_bcd0}, 32'h99);
    check("w99_over", {29'd0, q_over, q_winner}, 32'h5);
    goal99();
    check("w99_nowrap", {24'd0, q1_bcd1, q1_bcd0}, 32'h99);

    check("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
